// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult_ctrl
// Brief    : Sequencer for a shift-and-add multiplier (LOAD, ADD/SHIFT x WIDTH, DONE)
// Revision : 1.0
// ============================================================================
module shift_add_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic mplier_lsb,
    output logic load_ops,
    output logic clr_acc,
    output logic acc_en,
    output logic shift_en,
    output logic busy,
    output logic done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_WIDTH = CNT_W'(WIDTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] ADD   = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] count_inc;

    // Counter is sized to hold WIDTH itself, so the final increment never wraps.
    assign count_inc = count + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (abort) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = LOAD;
                    end
                end
                LOAD: begin
                    state_nxt = ADD;
                    count_nxt = '0;
                end
                ADD: begin
                    state_nxt = SHIFT;
                end
                SHIFT: begin
                    count_nxt = count_inc;
                    state_nxt = (count_inc < C_WIDTH) ? ADD : DONE;
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Moore decode; acc_en alone passes the multiplier LSB straight through.
    always_comb begin
        load_ops = 1'b0;
        clr_acc  = 1'b0;
        acc_en   = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            LOAD: begin
                load_ops = 1'b1;
                clr_acc  = 1'b1;
            end
            ADD: begin
                acc_en = mplier_lsb;
            end
            SHIFT: begin
                shift_en = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`default_nettype none
// Bench for shift_add_mult_ctrl: WIDTH=4 and WIDTH=1 instances, scoreboard of
// expected operations consumed by a negedge monitor on each done pulse.
module tb_shift_add_mult_ctrl;

    typedef struct {
        int          inst;
        int          lat;
        logic [31:0] acc;
        int          shifts;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort;
    logic       mplier_lsb;
    logic [1:0] start;
    logic [1:0] lo, ca, ae, se, bz, dn;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    shift_add_mult_ctrl #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort), .mplier_lsb(mplier_lsb),
        .load_ops(lo[0]), .clr_acc(ca[0]), .acc_en(ae[0]), .shift_en(se[0]),
        .busy(bz[0]), .done(dn[0])
    );

    shift_add_mult_ctrl #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort), .mplier_lsb(mplier_lsb),
        .load_ops(lo[1]), .clr_acc(ca[1]), .acc_en(ae[1]), .shift_en(se[1]),
        .busy(bz[1]), .done(dn[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int width_of(input int inst);
        return (inst == 0) ? 4 : 1;
    endfunction

    function automatic logic [5:0] outs(input int i);
        return {lo[i], ca[i], ae[i], se[i], bz[i], dn[i]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Monitor: follows each operation from load_ops to done and settles it
    // against the oldest scoreboard entry.
    int          cyc[2];
    int          shifts[2];
    int          busyc[2];
    logic [31:0] accbits[2];
    bit          active[2];
    exp_t        mon_e;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                active[i] = 1'b0;
            end else begin
                if (lo[i]) begin
                    check($sformatf("w%0d_clr_with_load", width_of(i)), 32'(ca[i]), 32'd1);
                    active[i]  = 1'b1;
                    cyc[i]     = 1;
                    accbits[i] = '0;
                    shifts[i]  = 0;
                    busyc[i]   = bz[i] ? 1 : 0;
                end else if (active[i]) begin
                    cyc[i]++;
                    if (bz[i]) busyc[i]++;
                    check($sformatf("w%0d_clr_outside_load", width_of(i)), 32'(ca[i]), 32'd0);
                end
                if (active[i]) begin
                    if (ae[i] && cyc[i] < 32) accbits[i][cyc[i]] = 1'b1;
                    if (se[i]) shifts[i]++;
                end
                if (dn[i]) begin
                    if (sb.size() == 0 || sb[0].inst != i) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL w%0d_unexpected_done: actual done=1 required done=0 (t=%0t)",
                                 width_of(i), $time);
                    end else begin
                        mon_e = sb.pop_front();
                        check($sformatf("w%0d_done_cycle", width_of(i)), 32'(cyc[i]), 32'(mon_e.lat));
                        check($sformatf("w%0d_acc_en_pattern", width_of(i)), accbits[i], mon_e.acc);
                        check($sformatf("w%0d_shift_count", width_of(i)), 32'(shifts[i]), 32'(mon_e.shifts));
                        check($sformatf("w%0d_busy_cycles", width_of(i)), 32'(busyc[i]), 32'(mon_e.lat));
                    end
                    active[i] = 1'b0;
                end else if (!bz[i]) begin
                    active[i] = 1'b0;
                    check($sformatf("w%0d_idle_outputs", width_of(i)),
                          32'({lo[i], ca[i], ae[i], se[i], dn[i]}), 32'd0);
                end
            end
        end
    end

    // One operation from an IDLE cycle. m[k] is the multiplier LSB presented in
    // the k-th ADD cycle; every other cycle drives 1 to expose stray acc_en.
    task automatic run_op(input int inst, input logic [31:0] m, input bit hold,
                          input int busy_start_cyc, input int abort_cyc, input bit expect_done);
        int   w;
        int   lat;
        exp_t e;
        w   = width_of(inst);
        lat = 2 * w + 2;
        check($sformatf("w%0d_pre_idle", w), 32'(bz[inst]), 32'd0);
        e.inst   = inst;
        e.lat    = lat;
        e.acc    = '0;
        e.shifts = w;
        for (int k = 0; k < w; k++) if (m[k]) e.acc[2 + 2 * k] = 1'b1;
        if (expect_done) sb.push_back(e);
        start[inst] = 1'b1;
        mplier_lsb  = 1'b1;
        tick();
        for (int c = 1; c <= lat; c++) begin
            start[inst] = hold || (c == busy_start_cyc);
            mplier_lsb  = (c >= 2 && c <= 2 * w && (c % 2) == 0) ? m[(c - 2) / 2] : 1'b1;
            abort       = (c == abort_cyc);
            tick();
            if (c == abort_cyc) begin
                abort = 1'b0;
                check($sformatf("w%0d_busy_after_abort", w), 32'(bz[inst]), 32'd0);
                break;
            end
        end
        abort      = 1'b0;
        mplier_lsb = 1'b1;
        if (!hold) start[inst] = 1'b0;
        if (expect_done) check($sformatf("w%0d_op_completed", w), 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        start      = 2'b00;
        abort      = 1'b0;
        mplier_lsb = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("w4_reset_outputs", 32'(outs(0)), 32'd0);
        check("w1_reset_outputs", 32'(outs(1)), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;

        // First start after reset, multiplier bits 1,1,0,1
        run_op(0, 32'b1011, 1'b0, 0, 0, 1'b1);
        idle(2);
        // start pulsed again while busy in cycle 5
        run_op(0, 32'b0110, 1'b0, 5, 0, 1'b1);
        idle(12);
        // start held high: back-to-back operations
        run_op(0, 32'b1111, 1'b1, 0, 0, 1'b1);
        run_op(0, 32'b0001, 1'b0, 0, 0, 1'b1);
        idle(2);
        // abort in the second SHIFT cycle
        run_op(0, 32'b1010, 1'b0, 0, 5, 1'b0);
        idle(12);
        // abort in DONE still lets the done pulse through
        run_op(0, 32'b0101, 1'b0, 0, 10, 1'b1);
        idle(2);

        // start and abort together in IDLE
        start[0] = 1'b1;
        abort    = 1'b1;
        tick();
        check("w4_start_abort_load", 32'(lo[0]), 32'd0);
        check("w4_start_abort_busy", 32'(bz[0]), 32'd0);
        start[0] = 1'b0;
        abort    = 1'b0;
        idle(2);

        // asynchronous reset mid-cycle during ADD
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        #2;
        check("w4_acc_en_before_reset", 32'(ae[0]), 32'd1);
        rst = 1'b0;
        #1;
        check("w4_async_reset_outputs", 32'(outs(0)), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        run_op(0, 32'b1001, 1'b0, 0, 0, 1'b1);
        idle(12);

        // WIDTH=1: LOAD, ADD, SHIFT, DONE
        run_op(1, 32'b1, 1'b0, 0, 0, 1'b1);
        idle(2);
        run_op(1, 32'b0, 1'b0, 0, 0, 1'b1);
        idle(4);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
